pwm_capture: RTL and testbench

//  Receive end of the PWM path: measures period and high time of an external PWM input.

---
 rtl/pwm_capture_pkg.sv | 14 +
 rtl/pwm_capture_tick_gen.sv | 29 ++
 rtl/pwm_capture.sv | 142 ++++++++++++++
 tb/tb_pwm_capture.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// Shared PWM package: FSM state encoding and default sizing for a 25 MHz clock.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } pwm_state_e;

    // 25 clk cycles per tick gives 1 us resolution at 25 MHz
    localparam int PWM_PRESCALE_25MHZ = 25;
    localparam int PWM_W_DEFAULT      = 16;

endpackage

// File: rtl/pwm_capture_tick_gen.sv
// Free-running prescaler: one-clk tick strobe every PRESCALE clks.
module tick_gen #(
    parameter int PRESCALE = 25
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // wrap at terminal count; with PRESCALE=1 the counter sits at 0 and tick is constant 1
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) cnt_d = '0;
    end

    // prescale counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an async PWM input in prescaled ticks.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int PRESCALE = PWM_PRESCALE_25MHZ,
    parameter int W        = PWM_W_DEFAULT,
    parameter int TIMEOUT  = 65535
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    input  logic         clear,
    output logic [W-1:0] period_cnt,
    output logic [W-1:0] high_cnt,
    output logic         valid,
    output logic         timeout
);

    localparam logic [W-1:0] TO_LIM = W'(TIMEOUT);

    logic         tick;
    logic         sync1_q, sync2_q, sync3_q;
    logic         rise_q, fall_q;
    pwm_state_e   state_q, state_d;
    logic [W-1:0] per_ctr_q, per_ctr_d;
    logic [W-1:0] hi_ctr_q, hi_ctr_d;
    logic [W-1:0] period_q, period_d;
    logic [W-1:0] high_q, high_d;
    logic         valid_q, valid_d;
    logic         timeout_q, timeout_d;
    logic [W-1:0] start_val;

    tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    // 2-FF synchronizer, third FF for edge detect, registered single-clk edge strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            rise_q  <= sync2_q & ~sync3_q;
            fall_q  <= ~sync2_q & sync3_q;
        end
    end

    // a tick landing on the opening rise belongs to the new interval
    assign start_val = {{(W-1){1'b0}}, tick};

    // measurement FSM: next state, counters, result capture and timeout
    always_comb begin
        state_d   = state_q;
        per_ctr_d = per_ctr_q;
        hi_ctr_d  = hi_ctr_q;
        period_d  = period_q;
        high_d    = high_q;
        valid_d   = 1'b0;
        timeout_d = timeout_q;
        if (clear) begin
            // clear wins over any edge in the same clk; results are kept
            state_d   = ST_IDLE;
            timeout_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (rise_q) begin
                        per_ctr_d = start_val;
                        hi_ctr_d  = start_val;
                        state_d   = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (per_ctr_q >= TO_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        if (tick) per_ctr_d = sat_inc(per_ctr_q);
                        if (fall_q)    state_d  = ST_LOW;
                        else if (tick) hi_ctr_d = sat_inc(hi_ctr_q);
                    end
                end
                ST_LOW: begin
                    if (per_ctr_q >= TO_LIM) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (rise_q) begin
                        period_d  = per_ctr_q;
                        high_d    = hi_ctr_q;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        per_ctr_d = start_val;
                        hi_ctr_d  = start_val;
                        state_d   = ST_HIGH;
                    end else if (tick) begin
                        per_ctr_d = sat_inc(per_ctr_q);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // FSM state, counters and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            per_ctr_q <= '0;
            hi_ctr_q  <= '0;
            period_q  <= '0;
            high_q    <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_ctr_q <= per_ctr_d;
            hi_ctr_q  <= hi_ctr_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_cnt = period_q;
    assign high_cnt   = high_q;
    assign valid      = valid_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: vector table of PWM patterns plus corner-case sequences.
module tb_pwm_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        pwm1 = 1'b0;
    logic        pwm25 = 1'b0;
    logic [15:0] per1, hi1, per25, hi25;
    logic        v1, t1, v25, t25;

    int checks = 0;
    int errors = 0;
    int nv1 = 0;
    int nv25 = 0;
    int lp1 = 0, lh1 = 0, lp25 = 0, lh25 = 0;

    // 25 MHz
    always #20 clk = ~clk;

    pwm_capture #(.PRESCALE(1), .W(16), .TIMEOUT(200)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm1),
        .clear      (clear),
        .period_cnt (per1),
        .high_cnt   (hi1),
        .valid      (v1),
        .timeout    (t1)
    );

    pwm_capture #(.PRESCALE(25), .W(16), .TIMEOUT(65535)) dut25 (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwm_in     (pwm25),
        .clear      (clear),
        .period_cnt (per25),
        .high_cnt   (hi25),
        .valid      (v25),
        .timeout    (t25)
    );

    // record every valid pulse seen on each instance
    always @(negedge clk) begin
        if (v1) begin
            nv1 = nv1 + 1;
            lp1 = int'(per1);
            lh1 = int'(hi1);
        end
        if (v25) begin
            nv25 = nv25 + 1;
            lp25 = int'(per25);
            lh25 = int'(hi25);
        end
    end

    typedef struct {
        int period;
        int high;
        int ncyc;
        int exp_nvalid;
        int exp_per;
        int exp_hi;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    task automatic pwm_cycles(input int sel, input int per, input int hi, input int n);
        for (int c = 0; c < n; c++) begin
            if (sel == 1) pwm1 = 1'b1; else pwm25 = 1'b1;
            repeat (hi) tick1();
            if (sel == 1) pwm1 = 1'b0; else pwm25 = 1'b0;
            repeat (per - hi) tick1();
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick1();
        clear = 1'b0;
        repeat (3) tick1();
    endtask

    initial begin
        vec_t vecs[5];
        int   base;
        int   lat;
        int   tk;

        vecs[0] = '{100, 30, 3, 2, 100, 30};
        vecs[1] = '{ 50,  1, 3, 2,  50,  1};
        vecs[2] = '{ 64, 63, 3, 2,  64, 63};
        vecs[3] = '{ 20, 10, 4, 3,  20, 10};
        vecs[4] = '{ 10,  3, 4, 3,  10,  3};

        // reset state
        repeat (3) tick1();
        @(negedge clk);
        chk("rst_period", int'(per1), 0);
        chk("rst_high", int'(hi1), 0);
        chk("rst_valid", int'(v1), 0);
        chk("rst_timeout", int'(t1), 0);
        rst_n = 1'b1;
        repeat (3) tick1();

        // table: n cycles give n-1 results, first rise only arms
        foreach (vecs[i]) begin
            do_clear();
            base = nv1;
            pwm_cycles(1, vecs[i].period, vecs[i].high, vecs[i].ncyc);
            repeat (8) tick1();
            chk($sformatf("vec%0d_nvalid", i), nv1 - base, vecs[i].exp_nvalid);
            chk($sformatf("vec%0d_period", i), lp1, vecs[i].exp_per);
            chk($sformatf("vec%0d_high", i), lh1, vecs[i].exp_hi);
            chk($sformatf("vec%0d_timeout", i), int'(t1), 0);
        end

        // latency: valid 4 clks after the pin rises
        do_clear();
        pwm_cycles(1, 100, 30, 1);
        pwm1 = 1'b1;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (v1 && lat == 0) lat = k;
        end
        chk("valid_latency", lat, 4);
        pwm1 = 1'b0;
        repeat (5) tick1();

        // timeout on stuck-high input
        do_clear();
        base = nv1;
        pwm_cycles(1, 100, 30, 2);
        pwm1 = 1'b1;
        tk = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (t1 && tk == 0) tk = k;
        end
        chk_rng("timeout_latency", tk, 200, 210);
        chk("timeout_sticky", int'(t1), 1);
        chk("timeout_nvalid", nv1 - base, 2);
        chk("timeout_period_kept", int'(per1), 100);
        chk("timeout_high_kept", int'(hi1), 30);

        // resume: first rise arms only, next rise gives valid and clears timeout
        pwm1 = 1'b0;
        repeat (70) tick1();
        base = nv1;
        pwm1 = 1'b1;
        repeat (30) tick1();
        pwm1 = 1'b0;
        chk("resume_arm_nvalid", nv1 - base, 0);
        chk("resume_arm_timeout", int'(t1), 1);
        repeat (70) tick1();
        pwm1 = 1'b1;
        repeat (8) tick1();
        chk("resume_nvalid", nv1 - base, 1);
        chk("resume_timeout", int'(t1), 0);
        chk("resume_period", lp1, 100);
        chk("resume_high", lh1, 30);
        repeat (22) tick1();
        pwm1 = 1'b0;
        repeat (70) tick1();

        // reset asserted mid-HIGH
        do_clear();
        pwm_cycles(1, 100, 30, 2);
        pwm1 = 1'b1;
        repeat (10) tick1();
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_period", int'(per1), 0);
        chk("midrst_high", int'(hi1), 0);
        chk("midrst_valid", int'(v1), 0);
        chk("midrst_timeout", int'(t1), 0);
        pwm1 = 1'b0;
        repeat (3) tick1();
        rst_n = 1'b1;
        repeat (5) tick1();
        base = nv1;
        pwm_cycles(1, 100, 30, 1);
        chk("postrst_arm_nvalid", nv1 - base, 0);
        pwm1 = 1'b1;
        repeat (8) tick1();
        chk("postrst_nvalid", nv1 - base, 1);
        chk("postrst_period", lp1, 100);
        chk("postrst_high", lh1, 30);
        repeat (22) tick1();
        pwm1 = 1'b0;
        repeat (70) tick1();

        // clear coinciding with a closing rise: no valid, back to IDLE
        do_clear();
        pwm_cycles(1, 50, 1, 3);
        base = nv1;
        pwm1 = 1'b1;
        repeat (3) tick1();
        clear = 1'b1;
        tick1();
        clear = 1'b0;
        pwm1 = 1'b0;
        repeat (8) tick1();
        chk("clear_rise_nvalid", nv1 - base, 0);
        repeat (38) tick1();
        pwm1 = 1'b1;
        tick1();
        pwm1 = 1'b0;
        repeat (8) tick1();
        chk("clear_rearm_nvalid", nv1 - base, 0);

        // prescaled path: 100 tick period, 30 tick high
        base = nv25;
        pwm_cycles(25, 2500, 750, 3);
        repeat (8) tick1();
        chk("p25_nvalid", nv25 - base, 2);
        chk_rng("p25_period", lp25, 99, 101);
        chk_rng("p25_high", lh25, 29, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
